// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Sequences RV32I loads and stores onto a word-wide, single-port data memory
// that has no byte enables and a one-cycle registered read. Sub-word stores
// are done as read-modify-write.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned H/HU/W requests are rejected
//                                      (resp_err) with no memory access.
//                         undefined -> misaligned requests use forced
//                                      alignment (halfword lane = addr[1],
//                                      words ignore addr[1:0]).
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_store           1 = store, 0 = load
//   req_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_err            request rejected, qualified by resp_valid
//   resp_rdata          extended load result (0 for stores and errors)
//   Address             word index {2'b00, addr[31:2]} to data memory
//   Mem_write_data      word written when MemRW = 1
//   MemRW               1 = write on this edge, 0 = read on this edge
//   Mem_read_data       memory word, valid one cycle after a read edge
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE; req_valid in any other
// state is ignored. The response is resp_valid for exactly one cycle with
// resp_err/resp_rdata valid in that same cycle; there is no back-pressure.
//
// The FSM state is held in the signal `state` (type state_t).
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] Address,
    output logic [31:0] Mem_write_data,
    output logic        MemRW,
    input  logic [31:0] Mem_read_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;    // merged word for SB/SH
    logic [31:0] rdata_q;   // extended load result

    logic        accept;
    logic        illegal;
    logic        is_sw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = (state == IDLE) && req_valid;
    assign is_sw  = req_store && (req_funct3 == 3'b010);

    // Request legality, decoded from the live request fields.
    always_comb begin
        illegal = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            illegal = 1'b1;
        if (req_store && !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                           req_funct3 == 3'b010))
            illegal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        // funct3[1:0] = 01 covers H/HU, 10 covers W.
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            illegal = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    // Lane selection from the sampled memory word.
    always_comb begin
        ld_byte = Mem_read_data[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = Mem_read_data[7:0];
            2'd1:    ld_byte = Mem_read_data[15:8];
            2'd2:    ld_byte = Mem_read_data[23:16];
            default: ld_byte = Mem_read_data[31:24];
        endcase
        ld_half = addr_q[1] ? Mem_read_data[31:16] : Mem_read_data[15:0];

        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = Mem_read_data;
        endcase
    end

    // Read-modify-write merge: only the addressed byte/halfword changes.
    always_comb begin
        merged = Mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0]  = wdata_q[15:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal)
                        state_next = ERR;
                    else if (is_sw)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = store_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
        end else if (accept) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
        end else if (state == CAPTURE) begin
            if (store_q)
                word_q  <= merged;
            else
                rdata_q <= load_ext;
        end
    end

    // MemRW is decoded straight from the state register so an asynchronous
    // reset in WRITE drops it immediately.
    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP) || (state == ERR);
    assign resp_err       = (state == ERR);
    assign resp_rdata     = (state == RESP) ? rdata_q : 32'd0;
    assign Address        = {2'b00, addr_q[31:2]};
    // Only SW reaches WRITE with funct3[1] set; it writes the latched word.
    assign Mem_write_data = funct3_q[1] ? wdata_q : word_q;
    assign MemRW          = (state == WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives directed and random requests into load_store_unit backed by a
// 64-word registered-read memory. A reference memory and arithmetic model
// give the expected response, latency, write count and written word.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int W = 37;  // {writes, err, latency[2:0], rdata[31:0]}

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] Address;
    logic [31:0] Mem_write_data;
    logic        MemRW;
    logic [31:0] Mem_read_data;

    logic [31:0]   mem [0:63];
    logic [31:0]   ref_mem [0:63];
    logic [W-1:0]  exp_q [$];
    logic [63:0]   wr_q [$];     // {word index, data}
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            acc_edge = 0;
    int            wr_cnt = 0;

    // ---------------- clock / reset / memory ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (MemRW) mem[Address[5:0]] <= Mem_write_data;
        Mem_read_data <= mem[Address[5:0]];
    end

    load_store_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .Address        (Address),
        .Mem_write_data (Mem_write_data),
        .MemRW          (MemRW),
        .Mem_read_data  (Mem_read_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        int          n;
        logic        err;
        logic [31:0] w;
        logic [31:0] r;
        logic [31:0] v;
        int          sh;
        int          lat;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end

        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3 > 3'd2);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) err = 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) err = 1'b1;
`endif
        w = ref_mem[(a / 4) % 64];
        r = 32'd0;
        lat = 1;
        if (!err && !st) begin
            lat = 3;
            if (f3 == 3'd0 || f3 == 3'd4) begin
                v = (w >> (8 * (a % 4))) & 32'hFF;
                r = (f3 == 3'd0 && v >= 128) ? v - 256 : v;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                r = (f3 == 3'd1 && v >= 32768) ? v - 65536 : v;
            end else begin
                r = w;
            end
        end else if (!err) begin
            if (f3 == 3'd2) begin
                lat = 2;
                v = wd;
            end else if (f3 == 3'd0) begin
                lat = 4;
                sh = 8 * (a % 4);
                v = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end else begin
                lat = 4;
                sh = 16 * ((a / 2) % 2);
                v = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            ref_mem[(a / 4) % 64] = v;
            wr_q.push_back({a / 4, v});
        end
        exp_q.push_back({st && !err, err, 3'(lat), r});

        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        acc_edge   = cyc + 1;
        @(negedge clock);
        // Unit is busy now: this request must be ignored.
        req_valid  = 1'b1;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        @(negedge clock);
        req_valid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", 32'(exp_q.size() + wr_q.size()), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [W-1:0] e;
        logic [63:0]  m;
        if (!reset) begin
            if (MemRW) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    m = wr_q.pop_front();
                    check("write_addr", Address, m[63:32]);
                    check("write_data", Mem_write_data, m[31:0]);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e[31:0]);
                    check("resp_err", 32'(resp_err), 32'(e[35]));
                    check("latency", 32'(cyc - acc_edge + 1), 32'(e[34:32]));
                    check("write_count", 32'(wr_cnt), 32'(e[36]));
                end
                wr_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        ref_mem[5] = 32'h8899AABC;
        mem[5]     = 32'h8899AABC;

        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_memrw", 32'(MemRW), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_address", Address, 32'd0);
        check("rst_mem_wdata", Mem_write_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // directed scenarios
        issue(1'b0, 3'b010, 32'h14, 32'd0);           // LW  -> 8899AABC
        issue(1'b0, 3'b000, 32'h15, 32'd0);           // LB  -> FFFFFFAA
        issue(1'b0, 3'b100, 32'h15, 32'd0);           // LBU -> 000000AA
        issue(1'b0, 3'b101, 32'h16, 32'd0);           // LHU -> 00008899
        issue(1'b0, 3'b001, 32'h16, 32'd0);           // LH  -> FFFF8899
        issue(1'b1, 3'b000, 32'h17, 32'h12345677);    // SB  -> 7799AABC
        issue(1'b0, 3'b010, 32'h14, 32'd0);
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);    // SW word 8
        issue(1'b0, 3'b010, 32'h20, 32'd0);
        issue(1'b0, 3'b010, 32'h22, 32'd0);           // misaligned LW
        issue(1'b1, 3'b001, 32'h13, 32'h0000CAFE);    // misaligned SH
        issue(1'b0, 3'b011, 32'h10, 32'd0);           // illegal funct3
        issue(1'b1, 3'b100, 32'h10, 32'h11111111);    // illegal store width
        issue(1'b0, 3'b111, 32'h10, 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++)
            issue(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);
        drain();

        // reset during the WRITE cycle of an SH to word 16
        begin
            int n;
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            req_valid  = 1'b1;
            req_store  = 1'b1;
            req_funct3 = 3'b001;
            req_addr   = 32'h40;
            req_wdata  = 32'h0000BEEF;
            @(posedge clock);            // accept -> READ
            #1 req_valid = 1'b0;
            @(posedge clock);            // -> CAPTURE
            @(posedge clock);            // -> WRITE
            #2;
            check("abort_in_write", 32'(MemRW), 32'd1);
            reset = 1'b1;
            #1;
            check("abort_memrw", 32'(MemRW), 32'd0);
            check("abort_req_ready", 32'(req_ready), 32'd1);
            check("abort_resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clock);
            @(negedge clock);
            reset = 1'b0;
            repeat (6) @(negedge clock);
        end
        issue(1'b0, 3'b010, 32'h40, 32'd0);           // word 16 unchanged
        drain();

        for (int i = 0; i < 64; i++)
            check("mem_word", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  1  core presents a memory request.
REQ-004 SHALL have port: req_ready  output  1  unit is in IDLE and can accept a request.
REQ-005 SHALL have port: req_store  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port: req_addr  input  32  byte address.
REQ-008 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: resp_err  output  1  request rejected (misaligned or illegal funct3); qualified by resp_valid.
REQ-011 SHALL have port: resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port: Address  output  32  word index to data memory, {2'b00, addr[31:2]}.
REQ-013 SHALL have port: Mem_write_data  output  32  full word written to memory.
REQ-014 SHALL have port: MemRW  output  1  1 = write this edge, 0 = read this edge.
REQ-015 SHALL have port: Mem_read_data  input  32  memory read word, valid one cycle after a read edge.

Function
REQ-016 Memory model SHALL be word-wide, no byte enables, single-cycle registered read; sub-word stores SHALL use read-modify-write.
REQ-017 FSM states SHALL be IDLE, READ, CAPTURE, WRITE, RESP, ERR; req_ready = 1 only in IDLE.
REQ-018 In IDLE with req_valid, the unit SHALL latch all req_* fields and transition as follows:
- to ERR if the request is illegal;
- to WRITE if it is an SW;
- to READ otherwise.
REQ-019 READ SHALL drive MemRW=0 and Address, then go to CAPTURE.
REQ-020 CAPTURE SHALL sample Mem_read_data, then act by request type:
- load: register the extended result and go to RESP;
- SB/SH: merge the store bytes into the sampled word and go to WRITE.
REQ-021 WRITE SHALL drive MemRW=1 with Address and the merged (or full, for SW) word for exactly one cycle, then go to RESP.
REQ-022 RESP SHALL assert resp_valid=1 and resp_err=0 for one cycle, then go to IDLE; ERR SHALL assert resp_valid=1 and resp_err=1 for one cycle, then go to IDLE.
REQ-023 MemRW SHALL be 1 only in WRITE; in all other states it SHALL be 0, and no memory write SHALL occur.
REQ-024 Latency from the accepting edge to resp_valid SHALL be:
- loads: 3 edges;
- SW: 2 edges;
- SB/SH: 4 edges;
- errors: 1 edge.
REQ-025 Byte lane SHALL be addr[1:0] and halfword lane addr[1]. B/H loads SHALL sign-extend; BU/HU loads SHALL zero-extend.
REQ-026 Merge SHALL replace only the addressed byte or halfword with req_wdata[7:0] or req_wdata[15:0]; all other bits SHALL be preserved.
REQ-027 funct3 values 011, 110 and 111, and funct3 != 000/001/010 for stores, SHALL be illegal.
REQ-028 req_valid while not in IDLE SHALL be ignored; the request is not latched.
REQ-029 Back-to-back operation: a request may be accepted in the IDLE cycle immediately following RESP or ERR.

Reset
REQ-030 On reset the unit SHALL immediately enter IDLE with the following values:
- req_ready = 1;
- resp_valid, resp_err, MemRW = 0;
- resp_rdata, Address, Mem_write_data = 0;
- all latched request registers = 0.
REQ-031 Reset asserted in any state, including WRITE, SHALL force MemRW=0 asynchronously; an aborted request SHALL produce no response and no memory write.

Configuration
REQ-032 The macro LSU_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-033 With LSU_MISALIGN_TRAP_EN defined, H/HU with addr[0]=1 and W with addr[1:0]!=0 SHALL be illegal and go to ERR with no memory access.
REQ-034 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed using forced alignment, and resp_err SHALL be set only for illegal funct3:
- halfword lane = addr[1], with addr[0] ignored;
- word accesses ignore addr[1:0].

Verification
REQ-035 Scenario: preload word 5 = 0x8899AABC, then LW addr 0x14 -> resp_rdata = 0x8899AABC at edge 3, with MemRW=0 throughout.
REQ-036 Scenario: word 5 = 0x8899AABC; LB addr 0x15 -> 0xFFFFFFAA; LBU addr 0x15 -> 0x000000AA; LHU addr 0x16 -> 0x00008899.
REQ-037 Scenario: word 5 = 0x8899AABC; SB addr 0x17 wdata 0x12345677 -> exactly one MemRW=1 cycle, writing 0x7799AABC; resp_valid at edge 4.
REQ-038 Scenario: SW addr 0x20 wdata 0xDEADBEEF -> WRITE cycle with Address=8; resp_valid at edge 2; a following LW returns 0xDEADBEEF.
REQ-039 Scenario: LW addr 0x22 -> with LSU_MISALIGN_TRAP_EN: resp_err=1 at edge 1, no memory access; without it: returns word 8.
REQ-040 Scenario: reset asserted during WRITE of an SH -> MemRW falls immediately, target word unchanged, req_ready=1, and no resp_valid.
